multi_channel_freq_divider: RTL

- N-channel programmable frequency divider / PWM generator. Each channel divides clk by a runtime-programmable period with a programmable on-time.
- Successor to the fixed-parameter single-channel divider. Adds runtime reprogramming, glitch-free shadow-register updates, per-channel enable and a period-boundary tick.
- Feeds timer, LED and baud-rate style consumers.

---
 rtl/multi_channel_freq_divider.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/multi_channel_freq_divider.sv
// ---------------------------------------------------------------------------
// multi_channel_freq_divider
//
// N-channel programmable frequency divider / PWM generator. Each channel
// counts 0..P-1 and drives div_out high while the counter is below ON.
// A one-cycle tick marks the last cycle of every period. New P/ON values are
// written into per-channel shadow registers and only become active at a
// period start, so a running waveform never shows a truncated period.
//
// Optional build macro: FREQ_DIV_SYNC_EN
//   When defined, adds input sync_in which restarts every enabled channel at
//   counter 0 on the next edge (phase alignment), with tick suppressed.
//
// Ports:
//   clk        clock
//   reset      synchronous, active-high reset
//   en         per-channel run enable
//   wr_en      single-cycle configuration write strobe
//   wr_ch      channel addressed by the write (out-of-range writes ignored)
//   wr_period  new period P (saturates to MAX_PERIOD)
//   wr_on      new on-time ON
//   sync_in    (FREQ_DIV_SYNC_EN only) phase-align all enabled channels
//   div_out    registered divided / PWM outputs
//   tick       registered one-cycle pulse on the last cycle of each period
// ---------------------------------------------------------------------------
module multi_channel_freq_divider #(
    parameter int NUM_CH         = 4,
    parameter int MAX_PERIOD     = 1024,
    parameter int CW             = $clog2(MAX_PERIOD + 1),
    parameter int CHW            = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    parameter int DEFAULT_PERIOD = 6,
    parameter int DEFAULT_ON     = DEFAULT_PERIOD / 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] en,
    input  logic              wr_en,
    input  logic [CHW-1:0]    wr_ch,
    input  logic [CW-1:0]     wr_period,
    input  logic [CW-1:0]     wr_on,
`ifdef FREQ_DIV_SYNC_EN
    input  logic              sync_in,
`endif
    output logic [NUM_CH-1:0] div_out,
    output logic [NUM_CH-1:0] tick
);

    logic          sync_s;
    logic [CW-1:0] wr_period_sat_s;

`ifdef FREQ_DIV_SYNC_EN
    assign sync_s = sync_in;
`else
    assign sync_s = 1'b0;
`endif

    // Clamp an oversized period write to the largest supported period.
    always_comb begin
        if (wr_period > CW'(MAX_PERIOD)) begin
            wr_period_sat_s = CW'(MAX_PERIOD);
        end else begin
            wr_period_sat_s = wr_period;
        end
    end

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        logic [CW-1:0] counter_r, shadow_p_r, shadow_on_r, act_p_r, act_on_r;
        logic          running_r, div_r, tick_r;
        logic [CW-1:0] counter_nxt_s, shadow_p_nxt_s, shadow_on_nxt_s;
        logic [CW-1:0] act_p_nxt_s, act_on_nxt_s, count_inc_s;
        logic          running_nxt_s, div_nxt_s, tick_nxt_s;
        logic          wr_hit_s, idle_s, restart_s;

        // Next-state logic: shadow update, period restart and counter stepping.
        always_comb begin
            // Equality with an existing channel index also rejects wr_ch >= NUM_CH.
            wr_hit_s        = wr_en && (wr_ch == CHW'(ch));
            shadow_p_nxt_s  = shadow_p_r;
            shadow_on_nxt_s = shadow_on_r;
            if (wr_hit_s) begin
                shadow_p_nxt_s  = wr_period_sat_s;
                shadow_on_nxt_s = wr_on;
            end else begin
                shadow_p_nxt_s  = shadow_p_r;
                shadow_on_nxt_s = shadow_on_r;
            end

            idle_s      = !en[ch] || (act_p_r < CW'(2));
            // A period starts on enable, on sync, or when the counter wraps.
            restart_s   = !running_r || sync_s || (counter_r == (act_p_r - CW'(1)));
            count_inc_s = counter_r + CW'(1);

            counter_nxt_s = counter_r;
            act_p_nxt_s   = act_p_r;
            act_on_nxt_s  = act_on_r;
            running_nxt_s = running_r;
            div_nxt_s     = 1'b0;
            tick_nxt_s    = 1'b0;

            if (idle_s) begin
                // Stopped or illegal period: outputs quiet, active tracks shadow.
                counter_nxt_s = '0;
                act_p_nxt_s   = shadow_p_nxt_s;
                act_on_nxt_s  = shadow_on_nxt_s;
                running_nxt_s = 1'b0;
            end else if (restart_s) begin
                // Shadow (or same-cycle write data) becomes active for this period.
                counter_nxt_s = '0;
                act_p_nxt_s   = shadow_p_nxt_s;
                act_on_nxt_s  = shadow_on_nxt_s;
                running_nxt_s = (shadow_p_nxt_s >= CW'(2));
                div_nxt_s     = (shadow_p_nxt_s >= CW'(2)) && (shadow_on_nxt_s != CW'(0));
            end else begin
                counter_nxt_s = count_inc_s;
                div_nxt_s     = (count_inc_s < act_on_r);
                tick_nxt_s    = (count_inc_s == (act_p_r - CW'(1)));
            end
        end

        // Channel state registers with synchronous reset to the defaults.
        always_ff @(posedge clk) begin
            if (reset) begin
                counter_r   <= '0;
                shadow_p_r  <= CW'(DEFAULT_PERIOD);
                shadow_on_r <= CW'(DEFAULT_ON);
                act_p_r     <= CW'(DEFAULT_PERIOD);
                act_on_r    <= CW'(DEFAULT_ON);
                running_r   <= 1'b0;
                div_r       <= 1'b0;
                tick_r      <= 1'b0;
            end else begin
                counter_r   <= counter_nxt_s;
                shadow_p_r  <= shadow_p_nxt_s;
                shadow_on_r <= shadow_on_nxt_s;
                act_p_r     <= act_p_nxt_s;
                act_on_r    <= act_on_nxt_s;
                running_r   <= running_nxt_s;
                div_r       <= div_nxt_s;
                tick_r      <= tick_nxt_s;
            end
        end

        assign div_out[ch] = div_r;
        assign tick[ch]    = tick_r;
    end

endmodule
